hv_assoc_search: RTL
====================

# hv_assoc_search

Associative-memory search unit forming the decode side of the HDC datapath. It accepts a query hypervector produced by the encoder's query HV register and streams class (prototype) hypervectors out of an external associative-memory array one per cycle. For each class it computes the Hamming distance to the query, then returns the index and distance of the closest class through a valid/ready result port.

## Interface
Parameters:
- HVDimension, 512, hypervector width in bits
- NumClass, 16, maximum number of class HVs in the associative memory
- ClassAddrWidth, $clog2(NumClass), class index / AM address width (derived, do not override)
- NumClassWidth, $clog2(NumClass+1), width of the class-count input (derived)
- DistWidth, $clog2(HVDimension+1), Hamming distance width (derived)

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- qhv_i  in  HVDimension  query hypervector, sampled on start handshake
- num_class_i  in  NumClassWidth  number of classes to search, sampled on start handshake
- start_valid_i  in  1  search request
- start_ready_o  out  1  high only in IDLE
- clr_i  in  1  synchronous abort; returns to IDLE, no result produced
- am_rd_en_o  out  1  AM read enable
- am_rd_addr_o  out  ClassAddrWidth  AM read address
- am_rd_data_i  in  HVDimension  AM read data, valid exactly 1 cycle after am_rd_en_o
- predict_o  out  ClassAddrWidth  index of closest class
- distance_o  out  DistWidth  Hamming distance of closest class
- predict_valid_o  out  1  result valid
- predict_ready_i  in  1  result consumed

## Operation
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE: start_ready_o=1. On start_valid_i=1, latch qhv_i into the query register and the effective count N into a register, then go to FETCH.
  - N = NumClass if num_class_i==0 or num_class_i>NumClass; otherwise N = num_class_i.
- FETCH: am_rd_en_o=1, and am_rd_addr_o equals the fetch counter, starting at 0 and incrementing by 1 each cycle.
  - The cycle issuing address N-1 transitions to DRAIN.
- Compare stage runs on every cycle following a read:
  - dist = popcount(query ^ am_rd_data_i).
  - The first compare of a search loads best_dist and best_idx unconditionally.
  - Each later compare updates them only if dist < best_dist (strict). On a tie the lower index wins.
- DRAIN: am_rd_en_o=0. The final compare happens this cycle, then the FSM goes to DONE.
- DONE: predict_valid_o=1, with predict_o=best_idx and distance_o=best_dist held stable. When predict_ready_i=1, go to IDLE.
- start_ready_o is low in every state except IDLE, so a new start is accepted no earlier than the cycle after the result handshake.
- clr_i in any state:
  - Next state is IDLE.
  - The fetch counter and compare-pending flag are zeroed.
  - predict_valid_o drops next cycle.
  - best_idx and best_dist are not cleared.
  - clr_i takes priority over start_valid_i and predict_ready_i in the same cycle.
- Query changes on qhv_i after the start handshake have no effect on the running search.

## Timing
- Reset values:
  - state IDLE, so start_ready_o=1.
  - am_rd_en_o=0, am_rd_addr_o=0.
  - predict_valid_o=0, predict_o=0, distance_o=0.
  - query register 0, counters 0.
- Reset asserted mid-search aborts immediately (asynchronously). No result is produced after release.
- Start accepted at cycle 0. Reads are issued at cycles 1..N and compares occur at cycles 2..N+1.
- predict_valid_o rises at cycle N+2. Latency from start handshake to valid is N+2 cycles; N=1 gives 3.
- Throughput: one class per cycle. Back-to-back searches cost N+3 cycles each when predict_ready_i is held high.
- popcount and compare form a single-cycle combinational path, registered into best_dist and best_idx.

## Test plan
- Reset then idle: after rst_i deasserts -> start_ready_o=1, predict_valid_o=0, am_rd_en_o=0, predict_o=0, distance_o=0.
- Exact match, NumClass=16, num_class_i=16, query equal to class 5, other classes random ->
  - reads at addresses 0..15 on cycles 1..16;
  - predict_valid_o at cycle 18 with predict_o=5, distance_o=0.
- Tie and strictness: classes 2 and 7 both at distance 3 from the query, all others at least 40 -> predict_o=2, distance_o=3.
- Edge counts:
  - num_class_i=1 with query=~class0 -> predict_o=0, distance_o=HVDimension, valid at cycle 3.
  - num_class_i=0 -> 16 reads issued.
  - num_class_i=20 (NumClassWidth widened) -> clamped to 16 reads.
- Backpressure: predict_ready_i held low for 10 cycles -> predict_valid_o stays high, outputs stable, start_ready_o=0, new start_valid_i ignored.
- Abort:
  - clr_i at cycle 6 of a 16-class search -> next cycle IDLE, am_rd_en_o=0, no predict_valid_o.
  - A fresh search started afterwards returns the correct result.
  - rst_i pulsed mid-search gives the same behaviour.

Source files
------------

// File: rtl/hv_assoc_search_if.sv
// Port bundle for the HDC associative-memory search unit: start request,
// associative-memory read port and result handshake.
interface hv_assoc_search_if #(
    parameter int HVDimension = 512,
    parameter int NumClass    = 16
) ();
    localparam int ClassAddrWidth = $clog2(NumClass);
    localparam int NumClassWidth  = $clog2(NumClass + 1);
    localparam int DistWidth      = $clog2(HVDimension + 1);

    logic [HVDimension-1:0]    qhv_i;
    logic [NumClassWidth-1:0]  num_class_i;
    logic                      start_valid_i;
    logic                      start_ready_o;
    logic                      clr_i;
    logic                      am_rd_en_o;
    logic [ClassAddrWidth-1:0] am_rd_addr_o;
    logic [HVDimension-1:0]    am_rd_data_i;
    logic [ClassAddrWidth-1:0] predict_o;
    logic [DistWidth-1:0]      distance_o;
    logic                      predict_valid_o;
    logic                      predict_ready_i;

    modport slave (
        input  qhv_i, num_class_i, start_valid_i, clr_i, am_rd_data_i, predict_ready_i,
        output start_ready_o, am_rd_en_o, am_rd_addr_o, predict_o, distance_o, predict_valid_o
    );

    modport master (
        output qhv_i, num_class_i, start_valid_i, clr_i, am_rd_data_i, predict_ready_i,
        input  start_ready_o, am_rd_en_o, am_rd_addr_o, predict_o, distance_o, predict_valid_o
    );
endinterface

// File: rtl/hv_assoc_search.sv
// Associative-memory search: streams class hypervectors one per cycle and
// reports the index and Hamming distance of the class closest to the query.
module hv_assoc_search #(
    parameter  int HVDimension    = 512,
    parameter  int NumClass       = 16,
    localparam int ClassAddrWidth = $clog2(NumClass),
    localparam int NumClassWidth  = $clog2(NumClass + 1),
    localparam int DistWidth      = $clog2(HVDimension + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    hv_assoc_search_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                    state_r, state_s;
    logic [HVDimension-1:0]    query_r;
    logic [NumClassWidth-1:0]  num_eff_r, num_eff_s;
    logic [ClassAddrWidth-1:0] fetch_cnt_r, cmp_idx_r, best_idx_r;
    logic [DistWidth-1:0]      best_dist_r, dist_s;
    logic                      cmp_pend_r, cmp_first_r;
    logic                      start_ready_r, am_rd_en_r, predict_valid_r;
    logic                      start_fire_s, last_fetch_s, best_upd_s;

    function automatic logic [DistWidth-1:0] popcount(input logic [HVDimension-1:0] v);
        logic [DistWidth-1:0] c;
        c = {DistWidth{1'b0}};
        for (int i = 0; i < HVDimension; i++) begin
            c = c + DistWidth'(v[i]);
        end
        return c;
    endfunction

    // Effective class count: zero or oversized requests search the full memory.
    always_comb begin
        if ((bus.num_class_i == {NumClassWidth{1'b0}}) ||
            (bus.num_class_i > NumClassWidth'(NumClass))) begin
            num_eff_s = NumClassWidth'(NumClass);
        end else begin
            num_eff_s = bus.num_class_i;
        end
    end

    assign start_fire_s = (state_r == IDLE) && bus.start_valid_i && !bus.clr_i;
    assign last_fetch_s = (NumClassWidth'(fetch_cnt_r) + NumClassWidth'(1)) == num_eff_r;
    assign dist_s       = popcount(query_r ^ bus.am_rd_data_i);

    // Next-state logic; clr_i overrides every other request.
    always_comb begin
        state_s = state_r;
        if (bus.clr_i) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_s = bus.start_valid_i ? FETCH : IDLE;
                FETCH:   state_s = last_fetch_s ? DRAIN : FETCH;
                DRAIN:   state_s = DONE;
                DONE:    state_s = bus.predict_ready_i ? IDLE : DONE;
                default: state_s = IDLE;
            endcase
        end
    end

    // Strict less-than keeps the lower index on a tie.
    always_comb begin
        if (cmp_pend_r && (cmp_first_r || (dist_s < best_dist_r))) begin
            best_upd_s = 1'b1;
        end else begin
            best_upd_s = 1'b0;
        end
    end

    // State, fetch counter, query latch and state-decoded output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r         <= IDLE;
            start_ready_r   <= 1'b1;
            am_rd_en_r      <= 1'b0;
            predict_valid_r <= 1'b0;
            fetch_cnt_r     <= {ClassAddrWidth{1'b0}};
            num_eff_r       <= {NumClassWidth{1'b0}};
            query_r         <= {HVDimension{1'b0}};
        end else begin
            state_r         <= state_s;
            start_ready_r   <= (state_s == IDLE);
            am_rd_en_r      <= (state_s == FETCH);
            predict_valid_r <= (state_s == DONE);
            if (bus.clr_i) begin
                fetch_cnt_r <= {ClassAddrWidth{1'b0}};
            end else if (start_fire_s) begin
                fetch_cnt_r <= {ClassAddrWidth{1'b0}};
                num_eff_r   <= num_eff_s;
                query_r     <= bus.qhv_i;
            end else if ((state_r == FETCH) && !last_fetch_s) begin
                fetch_cnt_r <= fetch_cnt_r + ClassAddrWidth'(1);
            end
        end
    end

    // Compare stage: tracks the read issued last cycle and the running best.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmp_pend_r  <= 1'b0;
            cmp_first_r <= 1'b0;
            cmp_idx_r   <= {ClassAddrWidth{1'b0}};
            best_idx_r  <= {ClassAddrWidth{1'b0}};
            best_dist_r <= {DistWidth{1'b0}};
        end else begin
            cmp_pend_r <= bus.clr_i ? 1'b0 : am_rd_en_r;
            cmp_idx_r  <= fetch_cnt_r;
            if (start_fire_s) begin
                cmp_first_r <= 1'b1;
            end else if (cmp_pend_r) begin
                cmp_first_r <= 1'b0;
            end
            if (best_upd_s) begin
                best_dist_r <= dist_s;
                best_idx_r  <= cmp_idx_r;
            end
        end
    end

    assign bus.start_ready_o   = start_ready_r;
    assign bus.am_rd_en_o      = am_rd_en_r;
    assign bus.am_rd_addr_o    = fetch_cnt_r;
    assign bus.predict_valid_o = predict_valid_r;
    assign bus.predict_o       = best_idx_r;
    assign bus.distance_o      = best_dist_r;
endmodule
